// File: rtl/rv32i_types_pkg.sv
// Shared RV32I out-of-order core types.
// Holds the common data bus payload, the CDB requester count and the
// symbolic names of the units that share the bus.
package rv32i_types;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROB_IDX_W = 5;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned AREG_W    = 5;

  parameter int unsigned NUM_CDB_REQ = 3;

  typedef enum logic [1:0] {
    CDB_SRC_ADD,
    CDB_SRC_MUL,
    CDB_SRC_DIV
  } cdb_src_t;

  // Result broadcast to reservation stations, ROB and physical register file.
  typedef struct packed {
    logic                 valid;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [PREG_W-1:0]    pd_s;
    logic [AREG_W-1:0]    rd_s;
    logic [XLEN-1:0]      rd_v;
  } cdb_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic rotating-priority arbiter (purely combinational).
// Ports:
//   i_req       request vector, one bit per requester
//   i_rr_ptr    index with highest priority this cycle
//   i_enable    0 forces every grant low
//   o_grant_c   one-hot grant
//   o_idx_c     index of the granted requester (0 when none)
//   o_valid_c   a grant was issued
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_rr_ptr,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [PTR_W-1:0]   o_idx_c,
  output logic               o_valid_c
);

  logic [PTR_W-1:0] w_idx;

  // Scan upward from the pointer, wrapping, and take the first request seen.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_idx     = '0;
    if (i_enable) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        w_idx = PTR_W'((32'(i_rr_ptr) + k) % NUM_REQ);
        if (!o_valid_c && i_req[w_idx]) begin
          o_grant_c[w_idx] = 1'b1;
          o_idx_c          = w_idx;
          o_valid_c        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus scheduler: picks one functional unit result per cycle in
// round-robin order and broadcasts it one cycle later.
// Ports:
//   clk        clock
//   rst        synchronous active-low reset
//   flush      squash outgoing broadcast and suppress grants this cycle
//   req_valid  per-unit result-ready flags (0 add, 1 mul, 2 div)
//   req_data   per-unit result payloads (.valid ignored)
//   req_ready  one-hot grant, combinational
//   cdb_out    registered broadcast
//   cdb_src    registered index of the unit that produced cdb_out
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_REQ = NUM_CDB_REQ,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_valid,
  input  cdb_t               req_data [NUM_REQ],
  output logic [NUM_REQ-1:0] req_ready,
  output cdb_t               cdb_out,
  output logic [PTR_W-1:0]   cdb_src
);

  logic [PTR_W-1:0]   r_rr_ptr;
  cdb_t               r_cdb;
  logic [PTR_W-1:0]   r_src;

  logic               w_enable;
  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_idx;
  logic               w_gnt;

  // Reset wins over flush; both keep every grant low.
  assign w_enable = rst && !flush;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .i_req     (req_valid),
    .i_rr_ptr  (r_rr_ptr),
    .i_enable  (w_enable),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_valid_c (w_gnt)
  );

  assign req_ready = w_grant;
  assign cdb_out   = r_cdb;
  assign cdb_src   = r_src;

  // Broadcast register and priority pointer; without a grant only .valid drops.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cdb    <= '0;
      r_src    <= '0;
      r_rr_ptr <= '0;
    end else if (w_gnt) begin
      r_cdb       <= req_data[w_idx];
      r_cdb.valid <= 1'b1;
      r_src       <= w_idx;
      r_rr_ptr    <= (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
    end else begin
      r_cdb.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: table of per-cycle vectors plus a
// hand-written reset-during-stream / back-to-back sequence.
module tb_cdb_arbiter;
  import rv32i_types::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [2:0] req_valid = 3'b000;
  cdb_t       req_data [3];
  logic [2:0] req_ready;
  cdb_t       cdb_out;
  logic [1:0] cdb_src;

  int tests = 0;
  int fails = 0;
  int proto_errs = 0;

  cdb_t pl [3];

  typedef struct {
    logic       rst;
    logic       flush;
    logic [2:0] req;
    logic [2:0] exp_ready;
    logic       exp_valid;
    logic       exp_zero;
    logic [1:0] exp_src;
    logic [1:0] exp_ptr;
  } vec_t;

  vec_t vecs [25];

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_out   (cdb_out),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  // Requesters must hold req_valid until granted.
  logic [2:0] r_pend = 3'b000;
  always @(posedge clk) begin
    if (rst && ((r_pend & ~req_valid) != 3'b000)) begin
      proto_errs = proto_errs + 1;
      $display("[TB] protocol violation: pending %b dropped, req_valid %b", r_pend, req_valid);
    end
    r_pend <= rst ? (req_valid & ~req_ready) : 3'b000;
  end

  function automatic vec_t mk(logic r, logic f, logic [2:0] q, logic [2:0] rdy,
                              logic v, logic z, logic [1:0] s, logic [1:0] p);
    vec_t t;
    t.rst = r; t.flush = f; t.req = q; t.exp_ready = rdy;
    t.exp_valid = v; t.exp_zero = z; t.exp_src = s; t.exp_ptr = p;
    return t;
  endfunction

  function automatic cdb_t model_cdb(logic z, logic v, logic [1:0] s);
    cdb_t c;
    if (z) c = '0;
    else begin
      c = pl[s];
      c.valid = v;
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive inputs mid-cycle, check the combinational grant, then step one edge.
  task automatic drive(input string tag, input logic r, input logic f,
                       input logic [2:0] q, input logic [2:0] rdy);
    @(negedge clk);
    rst = r; flush = f; req_valid = q;
    #1;
    chk({tag, " req_ready"}, 64'(req_ready), 64'(rdy));
    @(posedge clk);
    #1;
  endtask

  initial begin
    pl[0] = '{valid: 1'b0, rob_idx: 5'd5,  pd_s: 6'd10, rd_s: 5'd1, rd_v: 32'h1111_0000};
    pl[1] = '{valid: 1'b1, rob_idx: 5'd9,  pd_s: 6'd20, rd_s: 5'd2, rd_v: 32'h2222_0002};
    pl[2] = '{valid: 1'b0, rob_idx: 5'd12, pd_s: 6'd33, rd_s: 5'd0, rd_v: 32'hDEAD_BEEF};
    for (int i = 0; i < 3; i++) req_data[i] = pl[i];

    //               rst flush req     ready   v  zero src ptr
    vecs[0]  = mk(0, 0, 3'b111, 3'b000, 0, 1, 2'd0, 2'd0);
    vecs[1]  = mk(0, 0, 3'b111, 3'b000, 0, 1, 2'd0, 2'd0);
    vecs[2]  = mk(1, 0, 3'b111, 3'b001, 1, 0, 2'd0, 2'd1);
    vecs[3]  = mk(1, 0, 3'b111, 3'b010, 1, 0, 2'd1, 2'd2);
    vecs[4]  = mk(1, 0, 3'b111, 3'b100, 1, 0, 2'd2, 2'd0);
    vecs[5]  = mk(1, 0, 3'b111, 3'b001, 1, 0, 2'd0, 2'd1);
    vecs[6]  = mk(1, 0, 3'b110, 3'b010, 1, 0, 2'd1, 2'd2);
    vecs[7]  = mk(1, 0, 3'b100, 3'b100, 1, 0, 2'd2, 2'd0);
    vecs[8]  = mk(1, 0, 3'b100, 3'b100, 1, 0, 2'd2, 2'd0);
    vecs[9]  = mk(1, 0, 3'b100, 3'b100, 1, 0, 2'd2, 2'd0);
    vecs[10] = mk(1, 0, 3'b000, 3'b000, 0, 0, 2'd2, 2'd0);
    vecs[11] = mk(1, 0, 3'b001, 3'b001, 1, 0, 2'd0, 2'd1);
    vecs[12] = mk(1, 0, 3'b011, 3'b010, 1, 0, 2'd1, 2'd2);
    vecs[13] = mk(1, 0, 3'b011, 3'b001, 1, 0, 2'd0, 2'd1);
    vecs[14] = mk(1, 0, 3'b010, 3'b010, 1, 0, 2'd1, 2'd2);
    vecs[15] = mk(1, 1, 3'b101, 3'b000, 0, 0, 2'd1, 2'd2);
    vecs[16] = mk(1, 0, 3'b101, 3'b100, 1, 0, 2'd2, 2'd0);
    vecs[17] = mk(1, 0, 3'b001, 3'b001, 1, 0, 2'd0, 2'd1);
    vecs[18] = mk(1, 0, 3'b000, 3'b000, 0, 0, 2'd0, 2'd1);
    vecs[19] = mk(0, 1, 3'b111, 3'b000, 0, 1, 2'd0, 2'd0);
    vecs[20] = mk(1, 1, 3'b111, 3'b000, 0, 1, 2'd0, 2'd0);
    vecs[21] = mk(1, 0, 3'b111, 3'b001, 1, 0, 2'd0, 2'd1);
    vecs[22] = mk(1, 0, 3'b110, 3'b010, 1, 0, 2'd1, 2'd2);
    vecs[23] = mk(1, 0, 3'b100, 3'b100, 1, 0, 2'd2, 2'd0);
    vecs[24] = mk(1, 0, 3'b000, 3'b000, 0, 0, 2'd2, 2'd0);

    for (int i = 0; i < 25; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tag, vecs[i].rst, vecs[i].flush, vecs[i].req, vecs[i].exp_ready);
      chk({tag, " cdb_out"}, 64'(cdb_out),
          64'(model_cdb(vecs[i].exp_zero, vecs[i].exp_valid, vecs[i].exp_src)));
      chk({tag, " cdb_src"}, 64'(cdb_src), 64'(vecs[i].exp_src));
      chk({tag, " rr_ptr"}, 64'(dut.r_rr_ptr), 64'(vecs[i].exp_ptr));
    end

    // Reset arrives while a grant to div is pending; it must not be replayed.
    drive("rs0", 1, 0, 3'b111, 3'b001);
    drive("rs1", 1, 0, 3'b111, 3'b010);
    chk("rs1 rr_ptr", 64'(dut.r_rr_ptr), 64'd2);
    drive("rs2", 0, 0, 3'b111, 3'b000);
    chk("rs2 cdb_out", 64'(cdb_out), 64'd0);
    chk("rs2 rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
    drive("rs3", 1, 0, 3'b111, 3'b001);
    chk("rs3 cdb_out", 64'(cdb_out), 64'(model_cdb(0, 1, 2'd0)));

    // Back-to-back broadcasts with no bubble: rob_idx 9,12,5,9.
    begin
      logic [2:0] gseq [4];
      logic [1:0] sseq [4];
      gseq[0] = 3'b010; gseq[1] = 3'b100; gseq[2] = 3'b001; gseq[3] = 3'b010;
      sseq[0] = 2'd1;   sseq[1] = 2'd2;   sseq[2] = 2'd0;   sseq[3] = 2'd1;
      for (int i = 0; i < 4; i++) begin
        string tag;
        tag = $sformatf("b2b%0d", i);
        drive(tag, 1, 0, 3'b111, gseq[i]);
        chk({tag, " cdb_out"}, 64'(cdb_out), 64'(model_cdb(0, 1, sseq[i])));
        chk({tag, " cdb_src"}, 64'(cdb_src), 64'(sseq[i]));
      end
    end

    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    chk("protocol", 64'(proto_errs), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin scheduler that shares the single common data bus (CDB) among the add, multiply and divide functional units. Each cycle it grants at most one valid requester, registers that unit's `cdb_t` result and broadcasts it the next cycle to the reservation stations, ROB and physical register file. A rotating priority pointer keeps any unit from starving. A flush input squashes the outgoing broadcast on a mispredict.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesting functional units. Index 0 is add, 1 is multiply, 2 is divide.
- `PTR_W`, `$clog2(NUM_REQ)`: width of the priority pointer and of the grant index.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `flush`  in  1  squash the broadcast and suppress grants this cycle.
- `req_valid`  in  NUM_REQ  unit i holds a completed result.
- `req_data`  in  NUM_REQ x `cdb_t`  result payload per unit; the payload's `.valid` field is ignored.
- `req_ready`  out  NUM_REQ  one-hot grant; combinational from `req_valid`, `rr_ptr` and `flush`.
- `cdb_out`  out  `cdb_t`  registered broadcast.
- `cdb_src`  out  PTR_W  index of the unit that produced `cdb_out`; registered.

## Operation
- Handshake:
  - A transfer occurs when `req_valid[i] && req_ready[i]`.
  - A requester holds `req_valid` and `req_data` stable until it is granted.
  - Dropping `req_valid` before a grant is a protocol violation; the bench asserts on it.
- Arbitration:
  - Among the asserted `req_valid` bits, grant the first index found scanning upward from `rr_ptr` and wrapping from NUM_REQ-1 to 0.
  - At most one `req_ready` bit is high per cycle.
  - No request means all `req_ready` bits are 0.
- Pointer:
  - On a grant to index g, `rr_ptr` <= g+1, wrapping to 0 when g = NUM_REQ-1.
  - With no grant, `rr_ptr` holds.
- Broadcast:
  - On a grant, the next cycle has `cdb_out` = `req_data[g]` with `.valid`=1, and `cdb_src`=g.
  - With no grant, `cdb_out.valid` <= 0. The other `cdb_out` fields and `cdb_src` hold their last values.
- Payload:
  - Payload fields pass through unmodified.
  - `rd_s`=0 results are still broadcast so the ROB can commit them; consumers gate the register-file write themselves.
- Flush:
  - While `flush`=1, all `req_ready` bits are 0 and `cdb_out.valid` <= 0.
  - `rr_ptr` holds.
  - A broadcast already showing `cdb_out.valid`=1 in the flush cycle is still visible that cycle; consumers qualify it with `flush`.
- Reset (`rst`=0 at an edge):
  - `cdb_out` <= all zero, `cdb_src` <= 0, `rr_ptr` <= 0.
  - `req_ready` is forced to 0 while `rst`=0.
  - A grant pending when reset arrives is dropped; the arbiter does not replay it.

## Timing
- Latency: grant cycle N gives broadcast cycle N+1. `req_ready` is combinational in cycle N.
- Throughput: one broadcast per cycle while any request is valid, with no bubble between grants.
- Worst-case wait for a continuously valid requester is NUM_REQ-1 cycles.
- Simultaneous flush and request: flush wins; no grant, and the pointer does not move.
- Reset and flush both asserted: reset wins.
- Single requester continuously valid: granted every cycle; `rr_ptr` tracks g+1.
- Pointer wrap: a grant to index NUM_REQ-1 sets `rr_ptr`=0. Never produce a pointer ≥ NUM_REQ.

## Structure
- Shared package `rv32i_types`:
  - add `parameter NUM_CDB_REQ = 3`;
  - add `typedef enum logic [1:0] {CDB_SRC_ADD, CDB_SRC_MUL, CDB_SRC_DIV} cdb_src_t`;
  - reuse the existing `cdb_t`.
- Sub-module `rr_arbiter`: generic NUM_REQ-wide rotating-priority arbiter.
  - Inputs: request vector, `rr_ptr`, `enable`.
  - Output: one-hot grant and grant index.
  - Purely combinational; `rr_ptr` lives in `cdb_arbiter`.
- `cdb_arbiter` owns `rr_ptr`, the output register, the flush and reset gating, and the payload mux.

## Test plan
- Reset, then hold `rst`=0 for 2 cycles with all requests high → `req_ready`=000, `cdb_out.valid`=0, `cdb_src`=0; after release the first grant goes to index 0.
- All three units valid continuously, `rob_idx` 5/9/12 for add/mul/div → grants 0,1,2,0,… and `cdb_out.rob_idx` sequence 5,9,12,5 one cycle behind each grant, with no bubbles.
- Only the divide unit valid with `pd_s`=33 → `req_ready`=100 every cycle; `cdb_out.pd_s`=33 with `.valid`=1 each following cycle and `cdb_src`=2.
- Add and mul valid, `rr_ptr`=1 → mul granted first, then add; `rr_ptr` goes 1→2→1.
- `flush`=1 for one cycle while add and div are valid → `req_ready`=000 and the next `cdb_out.valid`=0; `rr_ptr` is unchanged, and the following cycle grants the same index it would have granted before the flush.
- Requests stop after a grant with `rd_v`=0xDEADBEEF → `cdb_out.valid` falls to 0, `rd_v` holds 0xDEADBEEF, and `rr_ptr` holds.
